ser_disp_rx: RTL and testbench

- Receive-side model of the board's serial display shift-register chain (7-seg tubes / LED bar).
- Samples the 4-wire stream driven by the display driver (clk, pen, clr_n, do) using the system clock.
- Shifts the data in and latches a parallel frame on each pen rising edge.
- Reports frame integrity to the bench or to a debug readback register; instanced once per chain (seg: WIDTH=64, led: WIDTH=16).

---
 rtl/ser_disp_pkg.sv | 19 +
 rtl/sync_edge.sv | 36 +++
 rtl/ser_disp_rx.sv | 137 +++++++++++++
 tb/tb_ser_disp_rx.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ser_disp_pkg.sv
// Shared definitions for the serial display receive chain.
// Holds synchronizer depth, default chain widths and the latch classification.
package ser_disp_pkg;

    // Number of flops each asynchronous ser_* input passes through
    localparam int SYNC_STAGES = 2;

    // Chain lengths of the two display chains on the board
    localparam int SEG_WIDTH = 64;
    localparam int LED_WIDTH = 16;

    // Outcome of a pen rising edge
    typedef enum logic [1:0] {
        LATCH_NONE = 2'b00,
        LATCH_OK   = 2'b01,
        LATCH_ERR  = 2'b10
    } latch_result_e;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, plus a registered
// previous value so rising and falling edges of the synchronized level
// can be detected. STAGES must be at least 2.
module sync_edge
    import ser_disp_pkg::*;
#(
    parameter int   STAGES    = SYNC_STAGES,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Shift the raw input through the synchronizer and remember the last level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = sync_q[STAGES-1] & ~prev_q;
    assign fall  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/ser_disp_rx.sv
// Receive-side model of the serial display shift-register chain.
// Samples the driver's clk/pen/clr_n/do wires on the system clock, shifts
// the data MSB first, latches a parallel frame on each pen rising edge and
// flags whether exactly WIDTH bits were shifted since the last latch/clear.
module ser_disp_rx
    import ser_disp_pkg::*;
#(
    parameter int WIDTH  = SEG_WIDTH,
    parameter int CNT_W  = $clog2(WIDTH + 2),
    parameter int FCNT_W = 16
) (
    input  logic              clk_h,
    input  logic              rst_async_low,
    input  logic              ser_clk,
    input  logic              ser_pen,
    input  logic              ser_clr_n,
    input  logic              ser_do,
    output logic [WIDTH-1:0]  data_out,
    output logic              frame_ok,
    output logic              frame_err,
    output logic [CNT_W-1:0]  bit_count,
    output logic [FCNT_W-1:0] frame_cnt
);

    // Count that marks a complete frame, and the saturation ceiling that
    // lets an overrun be told apart from a good frame
    localparam logic [CNT_W-1:0] COUNT_FULL = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] COUNT_MAX  = CNT_W'(WIDTH + 1);

    logic sclk_level, sclk_rise, sclk_fall;
    logic pen_level,  pen_rise,  pen_fall;
    logic clr_level,  clr_rise,  clr_fall;
    logic do_level,   do_rise,   do_fall;

    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] shift_next;
    logic [CNT_W-1:0] count_next;
    latch_result_e    latch_result;

    sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_clk (
        .clk   (clk_h),
        .rst_n (rst_async_low),
        .d     (ser_clk),
        .level (sclk_level),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_pen (
        .clk   (clk_h),
        .rst_n (rst_async_low),
        .d     (ser_pen),
        .level (pen_level),
        .rise  (pen_rise),
        .fall  (pen_fall)
    );

    // clr_n idles high so a reset does not look like a clear request
    sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_clr (
        .clk   (clk_h),
        .rst_n (rst_async_low),
        .d     (ser_clr_n),
        .level (clr_level),
        .rise  (clr_rise),
        .fall  (clr_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_do (
        .clk   (clk_h),
        .rst_n (rst_async_low),
        .d     (ser_do),
        .level (do_level),
        .rise  (do_rise),
        .fall  (do_fall)
    );

    // Only the clk/pen rise and the clr/do levels drive logic; the rest are
    // by-products of the shared synchronizer and are left for synthesis to prune
    logic unused_sync;
    assign unused_sync = &{1'b0, sclk_level, sclk_fall, pen_level, pen_fall,
                           clr_rise, clr_fall, do_rise, do_fall};

    // Next shift-register contents and bit count: clear wins over a shift,
    // and the count stops one past a full frame so overruns stay visible
    always_comb begin
        shift_next = shift_reg;
        count_next = bit_count;
        if (!clr_level) begin
            shift_next = '0;
            count_next = '0;
        end else if (sclk_rise) begin
            shift_next = {shift_reg[WIDTH-2:0], do_level};
            if (bit_count != COUNT_MAX) begin
                count_next = bit_count + 1'b1;
            end
        end
    end

    // Classify a pen rising edge using the count that includes any same-cycle shift
    always_comb begin
        latch_result = LATCH_NONE;
        if (pen_rise) begin
            latch_result = (count_next == COUNT_FULL) ? LATCH_OK : LATCH_ERR;
        end
    end

    // Shift register and bit counter; a latch starts the next frame at zero
    always_ff @(posedge clk_h or negedge rst_async_low) begin
        if (!rst_async_low) begin
            shift_reg <= '0;
            bit_count <= '0;
        end else begin
            shift_reg <= shift_next;
            bit_count <= pen_rise ? '0 : count_next;
        end
    end

    // Parallel latch, one-cycle integrity pulses and the good-frame counter
    always_ff @(posedge clk_h or negedge rst_async_low) begin
        if (!rst_async_low) begin
            data_out  <= '0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            frame_cnt <= '0;
        end else begin
            frame_ok  <= (latch_result == LATCH_OK);
            frame_err <= (latch_result == LATCH_ERR);
            if (pen_rise) begin
                data_out <= shift_next;
            end
            if (latch_result == LATCH_OK) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ser_disp_rx.sv
// Self-checking bench for ser_disp_rx with a 64-bit chain.
// The reference model keeps the list of bits shifted since the last clear
// and the number shifted since the last latch, and derives the expected
// frame, count and pulse from those.
module tb_ser_disp_rx;

    localparam int WIDTH  = 64;
    localparam int CNT_W  = $clog2(WIDTH + 2);
    localparam int FCNT_W = 16;

    logic              clk_h;
    logic              rst_async_low;
    logic              ser_clk;
    logic              ser_pen;
    logic              ser_clr_n;
    logic              ser_do;
    logic [WIDTH-1:0]  data_out;
    logic              frame_ok;
    logic              frame_err;
    logic [CNT_W-1:0]  bit_count;
    logic [FCNT_W-1:0] frame_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit   hist[$];
    int   frame_len;
    int   m_fcnt;

    ser_disp_rx #(.WIDTH(WIDTH), .CNT_W(CNT_W), .FCNT_W(FCNT_W)) dut (
        .clk_h         (clk_h),
        .rst_async_low (rst_async_low),
        .ser_clk       (ser_clk),
        .ser_pen       (ser_pen),
        .ser_clr_n     (ser_clr_n),
        .ser_do        (ser_do),
        .data_out      (data_out),
        .frame_ok      (frame_ok),
        .frame_err     (frame_err),
        .bit_count     (bit_count),
        .frame_cnt     (frame_cnt)
    );

    initial clk_h = 1'b0;
    always #5 clk_h = ~clk_h;

    // Guard against a hung run
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Frame the chain would present: the most recent WIDTH bits since the
    // last clear, newest in bit 0, zero where nothing was shifted
    function automatic logic [63:0] expectedWord();
        logic [63:0] w;
        int n;
        w = '0;
        n = hist.size();
        for (int j = 0; j < n && j < WIDTH; j++) begin
            w[j] = hist[n - 1 - j];
        end
        return w;
    endfunction

    function automatic int expectedCount();
        return (frame_len > WIDTH + 1) ? WIDTH + 1 : frame_len;
    endfunction

    function automatic void modelPush(input bit b);
        hist.push_back(b);
        if (hist.size() > WIDTH) void'(hist.pop_front());
        frame_len++;
    endfunction

    // Shift one bit: data set up, then a 4-cycle-high serial clock pulse
    task automatic applyStimulus(input bit b);
        ser_do = b;
        repeat (2) @(negedge clk_h);
        ser_clk = 1'b1;
        repeat (4) @(negedge clk_h);
        ser_clk = 1'b0;
        repeat (2) @(negedge clk_h);
        modelPush(b);
    endtask

    task automatic shiftWord(input logic [63:0] w, input int n);
        logic [63:0] v;
        v = w;
        for (int i = n - 1; i >= 0; i--) applyStimulus(v[i]);
    endtask

    task automatic shiftRandom(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'($urandom_range(0, 1)));
    endtask

    task automatic checkCount(input string tag);
        checkOutput(tag, 64'(bit_count), 64'(expectedCount()));
    endtask

    // Raise pen (optionally together with a final shift), count pulses, check latch results
    task automatic pulsePen(input string tag, input bit with_bit, input bit b);
        int ok_seen;
        int err_seen;
        bit exp_ok;
        logic [63:0] exp_data;
        ok_seen = 0;
        err_seen = 0;
        if (with_bit) begin
            ser_do = b;
            repeat (2) @(negedge clk_h);
            ser_clk = 1'b1;
            modelPush(b);
        end
        ser_pen = 1'b1;
        exp_ok = (expectedCount() == WIDTH);
        exp_data = expectedWord();
        repeat (6) begin
            @(negedge clk_h);
            ok_seen += int'(frame_ok);
            err_seen += int'(frame_err);
        end
        ser_pen = 1'b0;
        ser_clk = 1'b0;
        repeat (4) @(negedge clk_h);
        if (exp_ok) m_fcnt = (m_fcnt + 1) % (1 << FCNT_W);
        frame_len = 0;
        checkOutput({tag, " ok pulses"}, 64'(ok_seen), exp_ok ? 64'd1 : 64'd0);
        checkOutput({tag, " err pulses"}, 64'(err_seen), exp_ok ? 64'd0 : 64'd1);
        checkOutput({tag, " data_out"}, data_out, exp_data);
        checkOutput({tag, " frame_cnt"}, 64'(frame_cnt), 64'(m_fcnt));
        checkOutput({tag, " bit_count after"}, 64'(bit_count), 64'd0);
    endtask

    // Hold clr_n low about five cycles, optionally with a serial clock edge inside
    task automatic clearPulse(input string tag, input bit with_clk);
        ser_clr_n = 1'b0;
        repeat (2) @(negedge clk_h);
        if (with_clk) ser_clk = 1'b1;
        repeat (3) @(negedge clk_h);
        hist.delete();
        frame_len = 0;
        checkOutput({tag, " count during clear"}, 64'(bit_count), 64'd0);
        ser_clk = 1'b0;
        ser_clr_n = 1'b1;
        repeat (3) @(negedge clk_h);
        checkOutput({tag, " count after clear"}, 64'(bit_count), 64'd0);
    endtask

    // Assert reset between clock edges and check outputs clear immediately
    task automatic doReset(input string tag);
        @(negedge clk_h);
        #2 rst_async_low = 1'b0;
        ser_clk = 1'b0;
        ser_pen = 1'b0;
        ser_clr_n = 1'b1;
        ser_do = 1'b0;
        #1;
        hist.delete();
        frame_len = 0;
        m_fcnt = 0;
        checkOutput({tag, " data_out"}, data_out, 64'd0);
        checkOutput({tag, " bit_count"}, 64'(bit_count), 64'd0);
        checkOutput({tag, " frame_cnt"}, 64'(frame_cnt), 64'd0);
        checkOutput({tag, " frame_ok"}, 64'(frame_ok), 64'd0);
        checkOutput({tag, " frame_err"}, 64'(frame_err), 64'd0);
        @(negedge clk_h);
        rst_async_low = 1'b1;
        repeat (3) @(negedge clk_h);
    endtask

    initial begin
        rst_async_low = 1'b0;
        ser_clk = 1'b0;
        ser_pen = 1'b0;
        ser_clr_n = 1'b1;
        ser_do = 1'b0;
        frame_len = 0;
        m_fcnt = 0;
        repeat (3) @(negedge clk_h);
        rst_async_low = 1'b1;
        repeat (3) @(negedge clk_h);
        $display("[TB] reset state");
        checkOutput("reset data_out", data_out, 64'd0);
        checkOutput("reset bit_count", 64'(bit_count), 64'd0);
        checkOutput("reset frame_cnt", 64'(frame_cnt), 64'd0);

        $display("[TB] full frame");
        shiftWord(64'hDEADBEEF01234567, 64);
        checkCount("full count");
        pulsePen("full", 1'b0, 1'b0);
        checkOutput("full literal", data_out, 64'hDEADBEEF01234567);

        $display("[TB] underrun from reset");
        doReset("rst1");
        shiftWord(64'h2CE, 10);
        checkCount("under count");
        pulsePen("under", 1'b0, 1'b0);
        checkOutput("under literal", data_out, 64'h2CE);

        $display("[TB] overrun");
        shiftWord(64'h3, 2);
        shiftWord(64'hFFFF0000FFFF0000, 64);
        checkOutput("over saturated", 64'(bit_count), 64'd65);
        pulsePen("over", 1'b0, 1'b0);
        checkOutput("over literal", data_out, 64'hFFFF0000FFFF0000);

        $display("[TB] clear mid frame");
        shiftRandom(20);
        clearPulse("clr", 1'b1);
        shiftWord(64'h0123456789ABCDEF, 64);
        pulsePen("clr", 1'b0, 1'b0);
        checkOutput("clr literal", data_out, 64'h0123456789ABCDEF);

        $display("[TB] same-cycle shift and latch");
        shiftRandom(63);
        checkCount("edge count");
        pulsePen("edge", 1'b1, 1'b1);
        checkOutput("edge lsb", 64'(data_out[0]), 64'd1);

        $display("[TB] reset mid frame");
        shiftRandom(30);
        doReset("rst2");
        shiftWord(64'hA5A5A5A5A5A5A5A5, 64);
        pulsePen("after rst", 1'b0, 1'b0);
        checkOutput("after rst cnt", 64'(frame_cnt), 64'd1);

        $display("[TB] randomized frames");
        for (int f = 0; f < 8; f++) begin
            int len;
            len = ($urandom_range(0, 1) == 1) ? WIDTH : int'($urandom_range(1, 70));
            if ($urandom_range(0, 3) == 0) begin
                shiftRandom(int'($urandom_range(1, 20)));
                clearPulse("rnd", 1'b0);
            end
            shiftRandom(len);
            checkCount("rnd count");
            pulsePen("rnd", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
